// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Width of a requester index; never zero so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO-side signals of the write-port arbiter, bundled as one interface.
interface fifo_wr_arbiter_if #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 2,
  parameter int LEN_WIDTH = 8
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]           wr_valid;
  logic [NUM_REQ*BUS_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           wr_ready;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic                         fifo_push;
  logic [BUS_WIDTH-1:0]         fifo_din;
  logic                         fifo_full;

  // The arbiter itself.
  modport slave (
    input  req, req_len, wr_valid, wr_data, fifo_full,
    output gnt, wr_ready, done, busy, fifo_push, fifo_din
  );

  // Requesters plus FIFO, seen from outside the arbiter.
  modport master (
    output req, req_len, wr_valid, wr_data, fifo_full,
    input  gnt, wr_ready, done, busy, fifo_push, fifo_din
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  int cand;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    // The last winner is scanned last, so it only wins again when alone.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid           = 1'b1;
        winner_idx      = IDX_W'(cand);
        winner_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; a granted burst runs to completion
// before the next grant, so words from different requesters never interleave.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 2,
  parameter int LEN_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic [BUS_WIDTH-1:0] data_masked [NUM_REQ];
  logic [BUS_WIDTH-1:0] sel_data;
  logic                 sel_valid;
  logic                 in_burst;
  logic                 push;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (bus.req),
    .last       (last_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // AND-OR data mux keyed directly by the one-hot grant.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign data_masked[gi] = gnt_q[gi] ? bus.wr_data[gi*BUS_WIDTH +: BUS_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | data_masked[i];
    end
  end

  assign sel_valid = |(bus.wr_valid & gnt_q);
  assign in_burst  = (state_q == ARB_BURST);
  assign push      = in_burst && sel_valid && !bus.fifo_full;

  assign bus.fifo_push = push;
  assign bus.fifo_din  = push ? sel_data : '0;
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = in_burst;
  assign bus.wr_ready  = (in_burst && !bus.fifo_full) ? gnt_q : '0;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    count_d = count_q;
    done_d  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BURST;
          gnt_d   = pick_oh;
          last_d  = pick_idx;
          count_d = bus.req_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      ARB_BURST: begin
        // count holds words remaining minus one; the push at zero ends the burst.
        if (push) begin
          if (count_q == '0) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            done_d  = gnt_q;
          end else begin
            count_d = count_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: arbitration vector table, scoreboarded FIFO pushes,
// and hand-written stall, foreign-valid, mid-burst reset and long-burst sequences.
module tb_fifo_wr_arbiter;

  logic clk;
  logic reset;

  fifo_wr_arbiter_if #(.BUS_WIDTH(8), .NUM_REQ(2), .LEN_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.BUS_WIDTH(8), .NUM_REQ(2), .LEN_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    int         len;
    logic [1:0] exp_gnt;
  } vec_t;

  int         checks;
  int         errors;
  int         push_count;
  int         cnt [2];
  int         exp_cnt [2];
  logic [7:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Requester r emits words {r, sequence number}; queue the next n it should deliver.
  task automatic push_exp(input int r, input int n);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(8'(((r & 3) << 6) | (exp_cnt[r] & 63)));
      exp_cnt[r]++;
    end
  endtask

  task automatic set_len(input int l0, input int l1);
    bus.req_len = {8'(l1), 8'(l0)};
  endtask

  task automatic monitor_cycle();
    logic [7:0] w;
    if (bus.fifo_push) begin
      push_count++;
      check("push_while_full", 32'(bus.fifo_full), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got din %0h expected no push", bus.fifo_din);
      end else begin
        w = exp_q.pop_front();
        check("push_data", 32'(bus.fifo_din), 32'(w));
      end
    end else begin
      check("din_idle_zero", 32'(bus.fifo_din), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.wr_valid[i] && bus.wr_ready[i]) cnt[i]++;
    end
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (bus.gnt == 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.done != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [8];
    logic ok;
    int   pc0;
    int   occ;
    logic saw_full;
    logic done_seen;
    logic [1:0] done_val;

    tab[0] = '{2'b11, 0, 2'b01};
    tab[1] = '{2'b11, 0, 2'b10};
    tab[2] = '{2'b11, 0, 2'b01};
    tab[3] = '{2'b11, 0, 2'b10};
    tab[4] = '{2'b10, 2, 2'b10};
    tab[5] = '{2'b01, 1, 2'b01};
    tab[6] = '{2'b01, 0, 2'b01};
    tab[7] = '{2'b11, 3, 2'b10};

    checks = 0;
    errors = 0;
    push_count = 0;
    cnt[0] = 0; cnt[1] = 0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;

    reset         = 1'b1;
    bus.req       = 2'b11;
    bus.wr_valid  = 2'b11;
    bus.fifo_full = 1'b0;
    bus.wr_data   = '0;
    set_len(0, 0);

    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      forever begin
        @(posedge clk);
        #1;
        bus.wr_data = {8'(64 | (cnt[1] & 63)), 8'(cnt[0] & 63)};
      end
    join_none

    // Reset state, with requests and valids active to show they are ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_push", 32'(bus.fifo_push), 32'd0);
    bus.req = 2'b00;
    step();
    reset = 1'b0;

    // Arbitration table: back-to-back bursts, round-robin from requester 0.
    bus.wr_valid = 2'b11;
    bus.req = tab[0].req;
    set_len(tab[0].len, tab[0].len);
    push_exp(tab[0].exp_gnt[1] ? 1 : 0, tab[0].len + 1);
    for (int i = 0; i < 8; i++) begin
      wait_gnt(ok);
      check("tab_gnt_seen", 32'(ok), 32'd1);
      check("tab_gnt", 32'(bus.gnt), 32'(tab[i].exp_gnt));
      check("tab_busy", 32'(bus.busy), 32'd1);
      $display("vec %0d req=%b len=%0d gnt=%b", i, tab[i].req, tab[i].len, bus.gnt);
      wait_idle(ok);
      check("tab_idle_seen", 32'(ok), 32'd1);
      check("tab_done", 32'(bus.done), 32'(tab[i].exp_gnt));
      if (i < 7) begin
        bus.req = tab[i+1].req;
        set_len(tab[i+1].len, tab[i+1].len);
        push_exp(tab[i+1].exp_gnt[1] ? 1 : 0, tab[i+1].len + 1);
      end else begin
        bus.req = 2'b00;
      end
    end
    bus.wr_valid = 2'b00;
    check("tab_q_empty", 32'(exp_q.size()), 32'd0);

    // Single 4-word burst: one-cycle grant latency, consecutive pushes, one done pulse.
    step();
    bus.req = 2'b01;
    set_len(3, 0);
    bus.wr_valid = 2'b01;
    push_exp(0, 4);
    @(negedge clk);
    check("t1_gnt_latency", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("t1_gnt", 32'(bus.gnt), 32'd1);
    check("t1_push0", 32'(bus.fifo_push), 32'd1);
    bus.req = 2'b00;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t1_push_run", 32'(bus.fifo_push), 32'd1);
    end
    @(negedge clk);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_gnt_clear", 32'(bus.gnt), 32'd0);
    check("t1_busy_clear", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t1_done_once", 32'(bus.done), 32'd0);
    bus.wr_valid = 2'b00;
    $display("burst t1 words=4 done=ok");

    // 8-word burst stalled by fifo_full for 3 cycles.
    step();
    bus.req = 2'b01;
    set_len(7, 0);
    bus.wr_valid = 2'b01;
    push_exp(0, 8);
    pc0 = push_count;
    wait_gnt(ok);
    check("t3_gnt_seen", 32'(ok), 32'd1);
    bus.req = 2'b00;
    step();
    step();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_push_held", 32'(bus.fifo_push), 32'd0);
      check("t3_ready_held", 32'(bus.wr_ready), 32'd0);
      check("t3_busy_held", 32'(bus.busy), 32'd1);
      step();
    end
    bus.fifo_full = 1'b0;
    wait_done(ok);
    check("t3_done_seen", 32'(ok), 32'd1);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_push_total", 32'(push_count - pc0), 32'd8);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    bus.wr_valid = 2'b00;
    $display("burst t3 words=%0d stall=3", push_count - pc0);

    // Non-granted requester offers data throughout; granted one toggles valid.
    step();
    bus.req = 2'b01;
    set_len(3, 0);
    bus.wr_valid = 2'b11;
    push_exp(0, 4);
    pc0 = push_count;
    wait_gnt(ok);
    check("t4_gnt_seen", 32'(ok), 32'd1);
    check("t4_gnt", 32'(bus.gnt), 32'd1);
    bus.req = 2'b00;
    done_seen = 1'b0;
    for (int k = 0; k < 30 && !done_seen; k++) begin
      step();
      bus.wr_valid[0] = ~bus.wr_valid[0];
      @(negedge clk);
      check("t4_foreign_ready", 32'(bus.wr_ready[1]), 32'd0);
      if (bus.done != 2'b00) done_seen = 1'b1;
    end
    check("t4_done_seen", 32'(done_seen), 32'd1);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_push_total", 32'(push_count - pc0), 32'd4);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    bus.wr_valid = 2'b00;
    $display("burst t4 words=%0d", push_count - pc0);

    // Reset after 2 of 5 words: burst abandoned, no done, requester 0 wins first again.
    step();
    bus.req = 2'b01;
    set_len(4, 0);
    bus.wr_valid = 2'b01;
    push_exp(0, 2);
    pc0 = push_count;
    wait_gnt(ok);
    check("t5_gnt_seen", 32'(ok), 32'd1);
    bus.req = 2'b00;
    step();
    step();
    reset = 1'b1;
    bus.wr_valid = 2'b00;
    @(negedge clk);
    check("t5_no_push_at_reset", 32'(bus.fifo_push), 32'd0);
    step();
    reset = 1'b0;
    bus.req = 2'b11;
    bus.wr_valid = 2'b11;
    set_len(0, 0);
    push_exp(0, 1);
    @(negedge clk);
    check("t5_gnt_cleared", 32'(bus.gnt), 32'd0);
    check("t5_busy_cleared", 32'(bus.busy), 32'd0);
    check("t5_no_done", 32'(bus.done), 32'd0);
    check("t5_partial_pushes", 32'(push_count - pc0), 32'd2);
    @(negedge clk);
    check("t5_regrant_req0", 32'(bus.gnt), 32'd1);
    bus.req = 2'b00;
    @(negedge clk);
    check("t5_done", 32'(bus.done), 32'd1);
    bus.wr_valid = 2'b00;
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    $display("burst t5 reset_after=2 regrant=ok");

    // Maximum burst into an 8-deep FIFO drained one word every other cycle.
    step();
    bus.req = 2'b01;
    set_len(255, 0);
    bus.wr_valid = 2'b01;
    push_exp(0, 256);
    pc0 = push_count;
    occ = 0;
    saw_full = 1'b0;
    done_seen = 1'b0;
    done_val = 2'b00;
    for (int cyc = 0; cyc < 1500 && !done_seen; cyc++) begin
      logic pushed;
      @(negedge clk);
      pushed = bus.fifo_push;
      if (bus.gnt != 2'b00) bus.req = 2'b00;
      if (bus.done != 2'b00) begin
        done_seen = 1'b1;
        done_val = bus.done;
      end
      step();
      if (pushed) occ++;
      if ((cyc % 2) == 1 && occ > 0) occ--;
      bus.fifo_full = (occ >= 8);
      if (occ >= 8) saw_full = 1'b1;
    end
    bus.fifo_full = 1'b0;
    bus.wr_valid = 2'b00;
    check("t6_done_seen", 32'(done_seen), 32'd1);
    check("t6_done", 32'(done_val), 32'd1);
    check("t6_push_total", 32'(push_count - pc0), 32'd256);
    check("t6_fifo_filled", 32'(saw_full), 32'd1);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    $display("burst t6 words=%0d", push_count - pc0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
